// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI serial-clock engine.
// Pure declarations; no timing or flow control of its own.
package spi_pkg;

    localparam int SPI_DIV_W = 8;
    localparam int SPI_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } spi_state_t;

    // {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_halfper_cnt.sv
// Half-period down-counter: reloads on load_i or on reaching 0; tc_o flags that the next count is 0.
// tc_o is combinational so the caller can register the edge into the cycle it belongs to; no backpressure.
module spi_halfper_cnt #(
    parameter int DIV_W = 8
) (
    input  logic             clk_25,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            if (load_i || (cnt_q == '0)) begin
                cnt_d = load_val_i;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    assign tc_o = en_i && (cnt_d == '0);

    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI SCLK engine: registered SCLK and shift/sample strobes, edge k in cycle t+k*(div+1) after accept at t.
// No backpressure: start is ignored while busy. SPI_SCLK_CS_EN adds an active-low chip select.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DIV_W = SPI_DIV_W,
    parameter int CNT_W = SPI_CNT_W
) (
    input  logic             clk_25,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] nbits,
    input  logic             cpol,
    input  logic             cpha,
    output logic             sclk,
    output logic             shift_stb,
    output logic             sample_stb,
    output logic             busy,
    output logic             done,
    output logic             cs_n
);

    spi_state_t       state_q, state_d, cur;
    logic [DIV_W-1:0] div_q, div_eff;
    logic [CNT_W-1:0] nbits_q, nb_eff;
    logic             cpol_q, cpol_eff;
    logic             cpha_q, cpha_eff;
    logic [CNT_W:0]   edge_q, edge_d, edge_eff, k;
    logic             sclk_q, sclk_d, base_sclk;
    logic             shift_q, shift_d;
    logic             sample_q, sample_d;
    logic             done_q, done_d;
    logic             accept, tc, last;

    // The accept cycle acts on the incoming configuration so div==0 can place edge 1 at t+1.
    always_comb begin
        accept    = start && (state_q == IDLE);
        cur       = accept ? ((nbits == '0) ? HOLD : RUN) : state_q;
        div_eff   = accept ? div   : div_q;
        nb_eff    = accept ? nbits : nbits_q;
        cpol_eff  = accept ? cpol  : cpol_q;
        cpha_eff  = accept ? cpha  : cpha_q;
        edge_eff  = accept ? '0    : edge_q;
        base_sclk = accept ? cpol  : sclk_q;
        k         = edge_eff + 1'b1;
        last      = (k == {nb_eff, 1'b0});
    end

    spi_halfper_cnt #(.DIV_W(DIV_W)) u_halfper (
        .clk_25     (clk_25),
        .rst_n      (rst_n),
        .en_i       (cur != IDLE),
        .load_i     (accept),
        .load_val_i (div_eff),
        .tc_o       (tc)
    );

    always_comb begin
        state_d  = cur;
        edge_d   = edge_eff;
        sclk_d   = (cur == IDLE) ? cpol : base_sclk;
        shift_d  = 1'b0;
        sample_d = 1'b0;
        done_d   = 1'b0;
        if (tc) begin
            case (cur)
                RUN: begin
                    sclk_d = ~base_sclk;
                    edge_d = k;
                    if (k[0]) begin
                        shift_d  = cpha_eff;
                        sample_d = ~cpha_eff;
                    end else begin
                        sample_d = cpha_eff;
                        shift_d  = ~cpha_eff && !last;
                    end
                    if (last) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    sclk_d  = cpol_eff;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            div_q    <= '0;
            nbits_q  <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            edge_q   <= '0;
            sclk_q   <= 1'b0;
            shift_q  <= 1'b0;
            sample_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_eff;
            nbits_q  <= nb_eff;
            cpol_q   <= cpol_eff;
            cpha_q   <= cpha_eff;
            edge_q   <= edge_d;
            sclk_q   <= sclk_d;
            shift_q  <= shift_d;
            sample_q <= sample_d;
            done_q   <= done_d;
        end
    end

    assign sclk       = sclk_q;
    assign shift_stb  = shift_q;
    assign sample_stb = sample_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);

`ifdef SPI_SCLK_CS_EN
    assign cs_n = ~busy;
`else
    assign cs_n = 1'b1;
`endif

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Directed bench for spi_sclk_gen: every output checked every cycle against hand-derived edge timing.
// Cycle c is the interval after the c-th rising edge following the start cycle (c=0).
module tb_spi_sclk_gen;

    localparam int DIV_W = 8;
    localparam int CNT_W = 6;

`ifdef SPI_SCLK_CS_EN
    localparam bit CS_ON = 1'b1;
`else
    localparam bit CS_ON = 1'b0;
`endif

    logic             clk_25 = 1'b0;
    logic             rst_n  = 1'b0;
    logic             start  = 1'b0;
    logic [DIV_W-1:0] div    = '0;
    logic [CNT_W-1:0] nbits  = '0;
    logic             cpol   = 1'b0;
    logic             cpha   = 1'b0;
    logic             sclk, shift_stb, sample_stb, busy, done, cs_n;

    int vectors     = 0;
    int miscompares = 0;
    int n_shift     = 0;
    int n_sample    = 0;

    spi_sclk_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk_25     (clk_25),
        .rst_n      (rst_n),
        .start      (start),
        .div        (div),
        .nbits      (nbits),
        .cpol       (cpol),
        .cpha       (cpha),
        .sclk       (sclk),
        .shift_stb  (shift_stb),
        .sample_stb (sample_stb),
        .busy       (busy),
        .done       (done),
        .cs_n       (cs_n)
    );

    always #20 clk_25 = ~clk_25;

    task automatic tick();
        @(posedge clk_25);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, c, obs, exp);
        end
    endtask

    // One burst from an idle line; optional back-to-back restart and mid-burst reset.
    task automatic burst(input int d, input int n, input logic pl, input logic ph,
                         input bit b2b, input int abort_at);
        int   p, done_c, last_c, r, k, e;
        logic e_sclk, e_shift, e_sample, e_busy, e_done, e_cs;
        bit   scrambled;
        p         = d + 1;
        done_c    = (2 * n + 1) * p;
        scrambled = 1'b0;
        div   = DIV_W'(d);
        nbits = CNT_W'(n);
        cpol  = pl;
        cpha  = ph;
        tick();
        tick();
        chk("idle_sclk", 0, 32'(sclk), 32'(pl));
        chk("idle_busy", 0, 32'(busy), 32'd0);
        start    = 1'b1;
        n_shift  = 0;
        n_sample = 0;
        last_c   = b2b ? 2 * done_c + 2 : ((abort_at > 0) ? 40 : done_c + 3);
        for (int c = 1; c <= last_c; c++) begin
            tick();
            r        = (b2b && c > done_c) ? c - done_c : c;
            k        = ((r % p) == 0) ? r / p : 0;
            e        = (r / p < 2 * n) ? r / p : 2 * n;
            e_busy   = (r >= 1) && (r < done_c);
            e_done   = (r == done_c);
            e_sclk   = pl ^ logic'(e % 2);
            e_shift  = 1'b0;
            e_sample = 1'b0;
            if (k >= 1 && k <= 2 * n) begin
                if ((k % 2) == 1) begin
                    e_shift  = ph;
                    e_sample = !ph;
                end else begin
                    e_sample = ph;
                    e_shift  = !ph && (k != 2 * n);
                end
            end
            if (abort_at > 0 && c > abort_at) begin
                e_busy   = 1'b0;
                e_done   = 1'b0;
                e_shift  = 1'b0;
                e_sample = 1'b0;
                e_sclk   = (c == abort_at + 1) ? 1'b0 : pl;
            end
            e_cs = CS_ON ? !e_busy : 1'b1;
            chk("sclk",       c, 32'(sclk),       32'(e_sclk));
            chk("shift_stb",  c, 32'(shift_stb),  32'(e_shift));
            chk("sample_stb", c, 32'(sample_stb), 32'(e_sample));
            chk("busy",       c, 32'(busy),       32'(e_busy));
            chk("done",       c, 32'(done),       32'(e_done));
            chk("cs_n",       c, 32'(cs_n),       32'(e_cs));
            n_shift  += int'(shift_stb);
            n_sample += int'(sample_stb);
            if (c == 1) start = 1'b0;
            if (b2b && c == 10) start = 1'b1;
            if (b2b && c == 11) start = 1'b0;
            if (b2b && c == done_c) start = 1'b1;
            if (b2b && c == done_c + 1) start = 1'b0;
            if (abort_at == 0 && c == 5 && 5 < done_c - 1) begin
                div       = 8'd7;
                nbits     = 6'd3;
                cpol      = !pl;
                cpha      = !ph;
                scrambled = 1'b1;
            end
            if (scrambled && c == done_c - 1) begin
                div   = DIV_W'(d);
                nbits = CNT_W'(n);
                cpol  = pl;
                cpha  = ph;
            end
            if (abort_at > 0 && c == abort_at) rst_n = 1'b0;
            if (abort_at > 0 && c == abort_at + 1) rst_n = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        cpol  = 1'b1;
        tick();
        tick();
        tick();
        chk("rst_sclk",   0, 32'(sclk),       32'd0);
        chk("rst_shift",  0, 32'(shift_stb),  32'd0);
        chk("rst_sample", 0, 32'(sample_stb), 32'd0);
        chk("rst_busy",   0, 32'(busy),       32'd0);
        chk("rst_done",   0, 32'(done),       32'd0);
        chk("rst_cs_n",   0, 32'(cs_n),       32'd1);
        rst_n = 1'b1;
        tick();

        // Mode 0, div=1, nbits=8: done at 34, 8 samples and 7 shifts.
        burst(1, 8, 1'b0, 1'b0, 1'b0, 0);
        chk("m0_n_sample", 34, 32'(n_sample), 32'd8);
        chk("m0_n_shift",  34, 32'(n_shift),  32'd7);

        // Mode 3, div=0, nbits=1: fall+shift at 1, rise+sample at 2, done at 3.
        burst(0, 1, 1'b1, 1'b1, 1'b0, 0);
        chk("m3_n_sample", 3, 32'(n_sample), 32'd1);
        chk("m3_n_shift",  3, 32'(n_shift),  32'd1);

        // Mode 1 and mode 2 with other dividers.
        burst(2, 3, 1'b0, 1'b1, 1'b0, 0);
        chk("m1_n_shift", 21, 32'(n_shift), 32'd3);
        burst(0, 2, 1'b1, 1'b0, 1'b0, 0);
        chk("m2_n_shift", 5, 32'(n_shift), 32'd1);

        // nbits=0, div=3: no edges, done at 4.
        burst(3, 0, 1'b0, 1'b0, 1'b0, 0);
        chk("n0_strobes", 4, 32'(n_shift + n_sample), 32'd0);

        // Back-to-back with an ignored start at cycle 10.
        burst(1, 8, 1'b0, 1'b0, 1'b1, 0);
        chk("b2b_n_sample", 70, 32'(n_sample), 32'd16);

        // Reset at cycle 12 aborts the burst without done.
        burst(1, 8, 1'b0, 1'b0, 1'b0, 12);

        // Short burst used for the chip-select window (cs_n low 1..9, high at 10 when enabled).
        burst(1, 2, 1'b0, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
